vga_frame_monitor: RTL and testbench

VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

---
 rtl/vga_frame_monitor.sv | 161 ++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// VGA frame monitor: measures line/frame sync timing and an active-window RGB checksum
// per frame, and reports lock and sticky-error status against the expected timing.
module vga_frame_monitor #(
  parameter int H_TOTAL         = 800,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int H_ACTIVE        = 640,
  parameter int V_TOTAL         = 525,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int V_ACTIVE        = 480,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [15:0] rgb,
  input  logic        clr_err,
  output logic [11:0] meas_h_total,
  output logic [11:0] meas_h_sync,
  output logic [11:0] meas_v_total,
  output logic [11:0] meas_v_sync,
  output logic [23:0] checksum,
  output logic        frame_done,
  output logic        locked,
  output logic        err_sticky,
  output logic [15:0] frame_count
);

  // state    | meaning
  // UNLOCKED | after reset, waiting for the first v_sync edge to align
  // ACQUIRE  | measuring; no frame matched yet, or the last one mismatched
  // LOCKED   | measuring; the last frame matched all parameters
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic        POL     = (SYNC_ACTIVE_LOW != 0);
  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [12:0] H_LO    = 13'(H_SYNC + H_BP);
  localparam logic [12:0] H_HI    = 13'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [12:0] V_LO    = 13'(V_SYNC + V_BP);
  localparam logic [12:0] V_HI    = 13'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] H_TOT_C = 12'(H_TOTAL);
  localparam logic [11:0] H_SYN_C = 12'(H_SYNC);
  localparam logic [11:0] V_TOT_C = 12'(V_TOTAL);
  localparam logic [11:0] V_SYN_C = 12'(V_SYNC);

  state_t      state;
  logic        hs_prev, vs_prev;
  logic [11:0] h_cnt, v_cnt, v_width;
  logic [11:0] last_h_len, last_h_sync, last_v_sync;
  logic        line_err;
  logic [23:0] sum;

  logic        hs_act, vs_act, h_rise, h_fall, v_rise, v_fall;
  logic [11:0] h_inc, v_inc, vw_inc, cur_h, v_at_edge, cur_v;
  logic [11:0] m_h_total, m_h_sync;
  logic        in_win, line_err_nxt, frame_ok;
  logic [23:0] pix_val;

  assign hs_act = h_sync ^ POL;
  assign vs_act = v_sync ^ POL;
  assign h_rise = hs_act & ~hs_prev;
  assign h_fall = ~hs_act & hs_prev;
  assign v_rise = vs_act & ~vs_prev;
  assign v_fall = ~vs_act & vs_prev;

  // h_inc doubles as "h_cnt + 1" for line length and sync width, saturating like the counter
  assign h_inc  = (h_cnt == CNT_MAX) ? h_cnt : h_cnt + 12'd1;
  assign v_inc  = (v_cnt == CNT_MAX) ? v_cnt : v_cnt + 12'd1;
  assign vw_inc = (v_width == CNT_MAX) ? v_width : v_width + 12'd1;

  // Position of the current sample; v_at_edge counts a line ending on this sample
  assign cur_h     = h_rise ? 12'd0 : h_inc;
  assign v_at_edge = h_rise ? v_inc : v_cnt;
  assign cur_v     = v_rise ? 12'd0 : v_at_edge;

  assign in_win  = ({1'b0, cur_h} >= H_LO) && ({1'b0, cur_h} < H_HI) &&
                   ({1'b0, cur_v} >= V_LO) && ({1'b0, cur_v} < V_HI);
  assign pix_val = in_win ? {8'd0, rgb} : 24'd0;

  assign line_err_nxt = line_err | (h_rise && (h_inc != H_TOT_C)) |
                        (h_fall && (h_inc != H_SYN_C));
  assign m_h_total = h_rise ? h_inc : last_h_len;
  assign m_h_sync  = h_fall ? h_inc : last_h_sync;
  assign frame_ok  = (m_h_total == H_TOT_C) && (m_h_sync == H_SYN_C) &&
                     (v_at_edge == V_TOT_C) && (last_v_sync == V_SYN_C) && !line_err_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= UNLOCKED;
      hs_prev      <= 1'b0;
      vs_prev      <= 1'b0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      v_width      <= '0;
      last_h_len   <= '0;
      last_h_sync  <= '0;
      last_v_sync  <= '0;
      line_err     <= 1'b0;
      sum          <= '0;
      meas_h_total <= '0;
      meas_h_sync  <= '0;
      meas_v_total <= '0;
      meas_v_sync  <= '0;
      checksum     <= '0;
      frame_done   <= 1'b0;
      locked       <= 1'b0;
      err_sticky   <= 1'b0;
      frame_count  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (clr_err) err_sticky <= 1'b0;
      if (pix_en) begin
        hs_prev <= hs_act;
        vs_prev <= vs_act;
        if (v_rise) begin
          h_cnt       <= '0;
          v_cnt       <= '0;
          v_width     <= h_rise ? 12'd1 : 12'd0;
          last_h_len  <= '0;
          last_h_sync <= '0;
          last_v_sync <= '0;
          line_err    <= 1'b0;
          sum         <= pix_val;
          if (state == UNLOCKED) begin
            state <= ACQUIRE;
          end else begin
            meas_h_total <= m_h_total;
            meas_h_sync  <= m_h_sync;
            meas_v_total <= v_at_edge;
            meas_v_sync  <= last_v_sync;
            checksum     <= sum;
            frame_done   <= 1'b1;
            frame_count  <= frame_count + 16'd1;
            if (frame_ok) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              // placed after the clr_err clear so a coincident mismatch wins
              state      <= ACQUIRE;
              locked     <= 1'b0;
              err_sticky <= 1'b1;
            end
          end
        end else begin
          h_cnt <= cur_h;
          v_cnt <= v_at_edge;
          if (h_rise) last_h_len <= h_inc;
          if (h_fall) last_h_sync <= h_inc;
          if (h_rise && vs_act) v_width <= vw_inc;
          if (v_fall) last_v_sync <= v_width;
          line_err <= line_err_nxt;
          sum      <= sum + pix_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor using a reduced 32x16 timing so whole frames
// fit in a short run; expected values are hand-computed for that timing.
module tb_vga_frame_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pix_en = 1'b0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic [15:0] rgb = 16'h0000;
  logic        clr_err = 1'b0;
  logic [11:0] meas_h_total, meas_h_sync, meas_v_total, meas_v_sync;
  logic [23:0] checksum;
  logic        frame_done, locked, err_sticky;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail = 0;
  int div = 1;
  int fd_pulses = 0;
  int fd_cycles = 0;
  int p0;
  logic fd_q = 1'b0;
  logic fd0, fd1, fd_first, fd_second;

  vga_frame_monitor #(
    .H_TOTAL(32), .H_SYNC(4), .H_BP(2), .H_ACTIVE(24),
    .V_TOTAL(16), .V_SYNC(2), .V_BP(1), .V_ACTIVE(12),
    .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
    .rgb(rgb), .clr_err(clr_err),
    .meas_h_total(meas_h_total), .meas_h_sync(meas_h_sync),
    .meas_v_total(meas_v_total), .meas_v_sync(meas_v_sync),
    .checksum(checksum), .frame_done(frame_done), .locked(locked),
    .err_sticky(err_sticky), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) begin
      fd_cycles++;
      if (!fd_q) fd_pulses++;
    end
    fd_q = frame_done;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One pix_en sample; pins are active-low, hs/vs are the active levels
  task automatic sample(input logic hs, input logic vs, input logic [15:0] px);
    @(negedge clk);
    h_sync = ~hs;
    v_sync = ~vs;
    rgb    = px;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    fd0     = frame_done;
    pix_en  = 1'b0;
    clr_err = 1'b0;
    @(posedge clk);
    #1;
    fd1 = frame_done;
    for (int i = 2; i < div; i++) @(posedge clk);
  endtask

  task automatic gen_frame(input bit hs_en, input logic [15:0] px, input int long_l,
                           input int wide_l, input int nl);
    int len;
    int sw;
    logic act;
    for (int l = 0; l < nl; l++) begin
      len = (l == long_l) ? 33 : 32;
      sw  = (l == wide_l) ? 5 : 4;
      for (int p = 0; p < len; p++) begin
        act = (p >= 6) && (p < 30) && (l >= 3) && (l < 15);
        sample(hs_en && (p < sw), l < 2, act ? px : 16'h5A5A);
        if (l == 0 && p == 0) begin
          fd_first  = fd0;
          fd_second = fd1;
        end
      end
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_h_total", meas_h_total, 0);
    check("rst_checksum", checksum, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err_sticky, 0);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk);
    reset = 1'b1;

    // Nominal timing, pix_en every 4th clk, rgb = 1
    div = 4;
    gen_frame(1, 16'h0001, -1, -1, 16);
    check("f0_no_fd", fd_first, 0);
    check("f0_no_pulses", fd_pulses, 0);
    gen_frame(1, 16'h0001, -1, -1, 16);
    check("f1_fd_latency", fd_first, 1);
    check("f1_fd_clears", fd_second, 0);
    check("nom_h_total", meas_h_total, 32);
    check("nom_h_sync", meas_h_sync, 4);
    check("nom_v_total", meas_v_total, 16);
    check("nom_v_sync", meas_v_sync, 2);
    check("nom_checksum", checksum, 24'h000120);
    check("nom_locked", locked, 1);
    check("nom_frame_count", frame_count, 1);
    check("nom_err", err_sticky, 0);
    check("nom_one_pulse", fd_pulses, 1);

    // Full-scale pixels wrap the 24-bit checksum
    div = 1;
    gen_frame(1, 16'hFFFF, -1, -1, 16);
    check("f1_checksum", checksum, 24'h000120);
    check("f2_frame_count", frame_count, 2);
    gen_frame(1, 16'h0001, 5, -1, 16);
    check("wrap_checksum", checksum, 24'h1FFEE0);
    check("wrap_locked", locked, 1);
    check("wrap_frame_count", frame_count, 3);

    // Long line in frame 3
    gen_frame(1, 16'h0001, -1, -1, 16);
    check("long_locked", locked, 0);
    check("long_err", err_sticky, 1);
    check("long_h_total", meas_h_total, 32);
    check("long_checksum", checksum, 24'h000120);
    check("long_frame_count", frame_count, 4);
    gen_frame(1, 16'h0001, -1, -1, 16);
    check("relock_locked", locked, 1);
    check("relock_err_stays", err_sticky, 1);
    pulse_clr();
    check("clr_err", err_sticky, 0);
    check("clr_locked_kept", locked, 1);
    check("clr_count_kept", frame_count, 5);

    // Wide h_sync in one line, then a long line detected while clr_err is high
    gen_frame(1, 16'h0001, -1, 3, 16);
    gen_frame(1, 16'h0001, 2, -1, 16);
    check("wide_locked", locked, 0);
    check("wide_err", err_sticky, 1);
    check("wide_h_sync", meas_h_sync, 4);
    check("wide_frame_count", frame_count, 7);
    pulse_clr();
    check("clr_err2", err_sticky, 0);
    clr_err = 1'b1;
    gen_frame(1, 16'h0001, -1, -1, 16);
    check("set_wins_err", err_sticky, 1);
    check("set_wins_locked", locked, 0);
    check("set_wins_fd", fd_first, 1);
    gen_frame(1, 16'h0001, -1, -1, 8);
    check("pre_rst_locked", locked, 1);
    check("pre_rst_frame_count", frame_count, 9);

    // Reset mid-frame clears outputs at once
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_count", frame_count, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_err", err_sticky, 0);
    check("mid_rst_checksum", checksum, 0);
    check("mid_rst_h_total", meas_h_total, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // h_sync held inactive; first v_sync edge after reset gives no frame_done
    p0 = fd_pulses;
    gen_frame(0, 16'h0001, -1, -1, 16);
    check("rst_first_edge_no_fd", fd_pulses, p0);
    gen_frame(0, 16'h0001, -1, -1, 16);
    check("rst_second_edge_fd", fd_first, 1);
    check("nohs_pulses", fd_pulses, p0 + 1);
    check("nohs_h_total", meas_h_total, 0);
    check("nohs_v_total", meas_v_total, 0);
    check("nohs_h_sync", meas_h_sync, 0);
    check("nohs_v_sync", meas_v_sync, 0);
    check("nohs_checksum", checksum, 0);
    check("nohs_locked", locked, 0);
    check("nohs_frame_count", frame_count, 1);

    // Keep h_sync idle past 4096 samples; first line length reads the saturated count
    for (int i = 0; i < 3650; i++) sample(1'b0, 1'b0, 16'h5A5A);
    gen_frame(1, 16'h0001, -1, -1, 1);
    check("sat_h_total", meas_h_total, 12'hFFF);
    check("sat_v_total", meas_v_total, 1);
    check("sat_locked", locked, 0);
    check("sat_frame_count", frame_count, 2);
    check("fd_width", fd_cycles, fd_pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
